// File: rtl/nn_bram_pkg.sv
// Shared constants for the BRAM access arbiter: FSM states, requester indices, no-owner code.
package nn_bram_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWNED = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_e;

    localparam logic [1:0] REQ_WR     = 2'd0;
    localparam logic [1:0] REQ_RD     = 2'd1;
    localparam logic [1:0] REQ_PCPT   = 2'd2;
    localparam logic [1:0] OWNER_NONE = 2'd3;

endpackage

// File: rtl/bram_access_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: first set request at or after rr_ptr_i, wrapping 2->0.
module rr_pick3
    import nn_bram_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] rr_ptr_i,
    output logic       valid_o,
    output logic [1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = REQ_WR;
        case (rr_ptr_i)
            2'd1: begin
                if (req_i[1])      idx_o = REQ_RD;
                else if (req_i[2]) idx_o = REQ_PCPT;
                else               idx_o = REQ_WR;
            end
            2'd2: begin
                if (req_i[2])      idx_o = REQ_PCPT;
                else if (req_i[0]) idx_o = REQ_WR;
                else               idx_o = REQ_RD;
            end
            default: begin
                if (req_i[0])      idx_o = REQ_WR;
                else if (req_i[1]) idx_o = REQ_RD;
                else               idx_o = REQ_PCPT;
            end
        endcase
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// Round-robin arbiter granting one of three requesters exclusive use of a single BRAM port.
// Optional ownership watchdog enabled by defining BRAM_ARB_TIMEOUT_EN.
module bram_access_arbiter
    import nn_bram_pkg::*;
#(
    parameter int unsigned ADDR_W         = 9,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                req,
    input  logic [2:0]                rel,
    input  logic [3*ADDR_W-1:0]       req_addr,
    input  logic [3*(DATA_W/8)-1:0]   req_we,
    input  logic [3*DATA_W-1:0]       req_din,
    output logic [2:0]                gnt,
    output logic [1:0]                owner,
    output logic                      busy,
    output logic                      bram_en,
    output logic [DATA_W/8-1:0]       bram_we,
    output logic [ADDR_W-1:0]         bram_addr,
    output logic [DATA_W-1:0]         bram_din
`ifdef BRAM_ARB_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    localparam int unsigned BE_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 2 || (DATA_W % 8) != 0) begin : g_param_check
        $error("bram_access_arbiter: TIMEOUT_CYCLES must be >= 2 and DATA_W a multiple of 8");
    end

    arb_state_e state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic       busy_q, busy_d;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       own_req_c;
    logic       own_rel_c;

    rr_pick3 u_pick (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx)
    );

    // Current owner's request and release lines
    always_comb begin
        own_req_c = 1'b0;
        own_rel_c = 1'b0;
        case (owner_q)
            REQ_WR:   begin own_req_c = req[0]; own_rel_c = rel[0]; end
            REQ_RD:   begin own_req_c = req[1]; own_rel_c = rel[1]; end
            REQ_PCPT: begin own_req_c = req[2]; own_rel_c = rel[2]; end
            default:  begin own_req_c = 1'b0;   own_rel_c = 1'b0;   end
        endcase
    end

`ifdef BRAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;
    logic             expire_c;

    assign expire_c = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
`ifdef BRAM_ARB_TIMEOUT_EN
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_OWNED;
                    gnt_d    = 3'(3'b001 << pick_idx);
                    owner_d  = pick_idx;
                    rr_ptr_d = (pick_idx == REQ_PCPT) ? REQ_WR : 2'(pick_idx + 2'd1);
`ifdef BRAM_ARB_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            ARB_OWNED: begin
                if (own_rel_c || !own_req_c) begin
                    state_d = ARB_TURN;
                    gnt_d   = 3'b000;
                    owner_d = OWNER_NONE;
                end
`ifdef BRAM_ARB_TIMEOUT_EN
                else if (expire_c) begin
                    // rr_ptr already points past the revoked owner
                    state_d   = ARB_TURN;
                    gnt_d     = 3'b000;
                    owner_d   = OWNER_NONE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = CNT_W'(wd_cnt_q + CNT_W'(1));
                end
`endif
            end
            ARB_TURN: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = 3'b000;
                owner_d = OWNER_NONE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= 3'b000;
            owner_q  <= OWNER_NONE;
            rr_ptr_q <= REQ_WR;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef BRAM_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    // BRAM port mux: only the owner drives the port while OWNED
    always_comb begin
        bram_en   = 1'b0;
        bram_we   = '0;
        bram_addr = '0;
        bram_din  = '0;
        if (state_q == ARB_OWNED) begin
            bram_en = own_req_c;
            case (owner_q)
                REQ_WR: begin
                    bram_we   = req_we[0*BE_W +: BE_W];
                    bram_addr = req_addr[0*ADDR_W +: ADDR_W];
                    bram_din  = req_din[0*DATA_W +: DATA_W];
                end
                REQ_RD: begin
                    bram_we   = req_we[1*BE_W +: BE_W];
                    bram_addr = req_addr[1*ADDR_W +: ADDR_W];
                    bram_din  = req_din[1*DATA_W +: DATA_W];
                end
                REQ_PCPT: begin
                    bram_we   = req_we[2*BE_W +: BE_W];
                    bram_addr = req_addr[2*ADDR_W +: ADDR_W];
                    bram_din  = req_din[2*DATA_W +: DATA_W];
                end
                default: begin
                    bram_en = 1'b0;
                end
            endcase
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Exercises the watchdog when BRAM_ARB_TIMEOUT_EN is defined.
module tb_bram_access_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int TO     = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2:0]              req, rel;
    logic [3*ADDR_W-1:0]     req_addr;
    logic [3*BE_W-1:0]       req_we;
    logic [3*DATA_W-1:0]     req_din;
    logic [2:0]              gnt;
    logic [1:0]              owner;
    logic                    busy, bram_en;
    logic [BE_W-1:0]         bram_we;
    logic [ADDR_W-1:0]       bram_addr;
    logic [DATA_W-1:0]       bram_din;
    logic                    timeout;

    always #5 clk = ~clk;

    bram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .req_addr(req_addr), .req_we(req_we), .req_din(req_din),
        .gnt(gnt), .owner(owner), .busy(busy), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din)
`ifdef BRAM_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

`ifndef BRAM_ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the port, how many dead cycles remain, rotation start
    int m_owner = -1;
    int m_block = 0;
    int m_rr    = 0;
    int m_cnt   = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        bit found;
        m_to = 1'b0;
        found = 1'b0;
        if (rst) begin
            m_owner = -1; m_block = 0; m_rr = 0; m_cnt = 0;
        end else if (m_owner >= 0) begin
            if (rel[m_owner] || !req[m_owner]) begin
                m_owner = -1; m_block = 1;
            end
`ifdef BRAM_ARB_TIMEOUT_EN
            else if (m_cnt == TO - 1) begin
                m_owner = -1; m_block = 1; m_to = 1'b1;
            end else begin
                m_cnt++;
            end
`endif
        end else if (m_block > 0) begin
            m_block--;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_rr + k) % 3;
                if (!found && req[i]) begin
                    found = 1'b1;
                    m_owner = i;
                    m_rr = (i + 1) % 3;
                    m_cnt = 0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0]        e_gnt;
            logic [1:0]        e_own;
            logic              e_en;
            logic [BE_W-1:0]   e_we;
            logic [ADDR_W-1:0] e_addr;
            logic [DATA_W-1:0] e_din;
            e_gnt = '0; e_own = 2'd3; e_en = 1'b0; e_we = '0; e_addr = '0; e_din = '0;
            if (m_owner >= 0) begin
                e_gnt  = 3'(1 << m_owner);
                e_own  = 2'(m_owner);
                e_en   = req[m_owner];
                e_we   = req_we[m_owner*BE_W +: BE_W];
                e_addr = req_addr[m_owner*ADDR_W +: ADDR_W];
                e_din  = req_din[m_owner*DATA_W +: DATA_W];
            end
            chk("m_gnt", 64'(gnt), 64'(e_gnt));
            chk("m_owner", 64'(owner), 64'(e_own));
            chk("m_busy", 64'(busy), 64'((m_owner >= 0) || (m_block > 0)));
            chk("m_en", 64'(bram_en), 64'(e_en));
            chk("m_we", 64'(bram_we), 64'(e_we));
            chk("m_addr", 64'(bram_addr), 64'(e_addr));
            chk("m_din", 64'(bram_din), 64'(e_din));
            chk("m_timeout", 64'(timeout), 64'(m_to));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; rel = '0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int order [4];
        rst = 1'b1; req = '0; rel = '0; req_addr = '0; req_we = '0; req_din = '0;
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_owner", 64'(owner), 64'h3);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_en", 64'(bram_en), 64'h0);

        // Single requester
        req = 3'b001;
        req_addr[0 +: ADDR_W] = 9'h005;
        req_we[0 +: BE_W] = 4'hF;
        req_din[0 +: DATA_W] = 32'hDEADBEEF;
        step();
        chk("single_gnt", 64'(gnt), 64'h1);
        chk("single_en", 64'(bram_en), 64'h1);
        chk("single_addr", 64'(bram_addr), 64'h5);
        chk("single_din", 64'(bram_din), 64'hDEADBEEF);
        chk("single_we", 64'(bram_we), 64'hF);
        rel = 3'b001;
        step();
        rel = 3'b000;
        chk("single_rel_gnt", 64'(gnt), 64'h0);
        chk("single_rel_owner", 64'(owner), 64'h3);
        chk("single_turn_en", 64'(bram_en), 64'h0);
        req = 3'b000;
        step(); step();

        // Contention: order 0,1,2,0 with a fixed two-cycle gap
        do_reset();
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            while (gnt == 3'b000 && n < 10) begin
                step();
                n++;
            end
            order[g] = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : (gnt == 3'b100) ? 2 : -1;
            chk("cont_order", 64'(order[g]), 64'((g == 3) ? 0 : g));
            chk("cont_gap", 64'(n), 64'((g == 0) ? 1 : 2));
            step();
            rel = gnt;
            step();
            rel = 3'b000;
            chk("cont_rel_gnt", 64'(gnt), 64'h0);
        end
        req = 3'b000;
        step(); step();

        // Releases from non-owners are ignored
        do_reset();
        req = 3'b010;
        req_addr[ADDR_W +: ADDR_W] = 9'h1AB;
        req_we[BE_W +: BE_W] = 4'h5;
        req_din[DATA_W +: DATA_W] = 32'h12345678;
        step();
        chk("illegal_gnt0", 64'(gnt), 64'h2);
        rel = 3'b101;
        step();
        rel = 3'b000;
        chk("illegal_gnt", 64'(gnt), 64'h2);
        chk("illegal_addr", 64'(bram_addr), 64'h1AB);
        chk("illegal_we", 64'(bram_we), 64'h5);
        chk("illegal_din", 64'(bram_din), 64'h12345678);
        chk("illegal_en", 64'(bram_en), 64'h1);
        req = 3'b000;
        step(); step();

        // Reset during ownership
        do_reset();
        req = 3'b100;
        step();
        chk("rstmid_gnt", 64'(gnt), 64'h4);
        req_we[2*BE_W +: BE_W] = 4'b0011;
        #1;
        chk("rstmid_we", 64'(bram_we), 64'h3);
        rst = 1'b1;
        req = 3'b111;
        step();
        chk("rstmid_gnt0", 64'(gnt), 64'h0);
        chk("rstmid_en0", 64'(bram_en), 64'h0);
        chk("rstmid_owner", 64'(owner), 64'h3);
        rst = 1'b0;
        step();
        chk("rstmid_first", 64'(gnt), 64'h1);
        req = 3'b000;
        step(); step();

`ifdef BRAM_ARB_TIMEOUT_EN
        // Watchdog revokes a never-releasing owner
        do_reset();
        req = 3'b011;
        step();
        chk("to_gnt", 64'(gnt), 64'h1);
        n = 0;
        while (timeout == 1'b0 && n < 40) begin
            step();
            n++;
        end
        chk("to_delay", 64'(n), 64'(TO));
        chk("to_gnt_clear", 64'(gnt), 64'h0);
        step();
        chk("to_pulse_once", 64'(timeout), 64'h0);
        step();
        chk("to_next_gnt", 64'(gnt), 64'h2);
        req = 3'b000;
        step(); step();
`endif

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
                rel[b] = ($urandom_range(0, 9) == 0);
            end
            req_addr = {$urandom, $urandom};
            req_we   = 12'($urandom);
            req_din  = {$urandom, $urandom, $urandom};
            step();
        end

        rst = 1'b0; req = '0; rel = '0;
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_access_arbiter.md
BRAM_ACCESS_ARBITER -- requirements
Module: bram_access_arbiter

Interface
REQ-001 Parameter ADDR_W, default 9: BRAM address width.
REQ-002 Parameter DATA_W, default 32: BRAM data width; byte-enable width = DATA_W/8.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit, used only with BRAM_ARB_TIMEOUT_EN.
REQ-004 The port list SHALL be exactly:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  per-requester access request; bit0 = serial-to-BRAM writer, bit1 = BRAM-to-serial reader, bit2 = perceptron.
- rel  input  3  per-requester release pulse.
- req_addr  input  3*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_we  input  3*(DATA_W/8)  packed byte write enables.
- req_din  input  3*DATA_W  packed write data.
- gnt  output  3  one-hot grant, registered.
- owner  output  2  index of the granted requester; 2'd3 when none.
- busy  output  1  high in OWNED and TURNAROUND.
- bram_en  output  1  BRAM port enable.
- bram_we  output  DATA_W/8  BRAM byte write enable.
- bram_addr  output  ADDR_W  BRAM address.
- bram_din  output  DATA_W  BRAM write data.
- timeout  output  1  watchdog revoke pulse; present only with BRAM_ARB_TIMEOUT_EN.

Function
REQ-005 FSM states: IDLE, OWNED, TURNAROUND; state, gnt, owner and rr_ptr are registers.
REQ-006 IDLE: if any req bit is high at edge n, enter OWNED and assert the gnt bit chosen by round-robin at edge n, i.e. visible in cycle n+1 (one-cycle grant latency).
REQ-007 Round-robin: search starts at rr_ptr and wraps 2->0; on a grant to i, rr_ptr <= (i+1) mod 3.
REQ-008 OWNED: bram_addr, bram_we and bram_din are combinationally muxed from the owner's slice; bram_en = req[owner].
REQ-009 Outside OWNED: bram_en = 0, bram_we = 0, bram_addr = 0 and bram_din = 0.
REQ-010 OWNED exits to TURNAROUND, clearing gnt and setting owner = 3, when rel[owner] = 1 or req[owner] = 0.
REQ-011 TURNAROUND lasts exactly one cycle, then returns to IDLE; no grant is issued from TURNAROUND, even when req bits are pending.
REQ-012 rel bits from non-owners are ignored; rel in IDLE is ignored.
REQ-013 Releasing a requester whose req is still high competes again from IDLE, behind the others per rr_ptr.
REQ-014 At most one gnt bit is high in any cycle; gnt = 0 whenever state is not OWNED.
REQ-015 The arbiter passes no read data; requesters sample the BRAM douta bus directly while granted.

Reset
REQ-016 When rst = 1 at a clock edge: state <= IDLE, gnt <= 0, owner <= 3, rr_ptr <= 0, watchdog count <= 0, and timeout <= 0.
REQ-017 Reset applied during OWNED revokes the grant at that edge; bram_en is 0 in the following cycle.

Configuration
REQ-018 Macro BRAM_ARB_TIMEOUT_EN defined:
- A counter clears on entry to OWNED and increments each OWNED cycle.
- When the counter reaches TIMEOUT_CYCLES-1 without a release, the arbiter forces TURNAROUND and pulses timeout high for one cycle.
- rr_ptr advances past the revoked owner.
REQ-019 Macro BRAM_ARB_TIMEOUT_EN undefined: no counter is built, the timeout port is absent, and ownership is unbounded.

Structure
REQ-020 Shared package nn_bram_pkg holds:
- state encoding constants ARB_IDLE, ARB_OWNED, ARB_TURN;
- requester index constants REQ_WR = 0, REQ_RD = 1, REQ_PCPT = 2;
- OWNER_NONE = 2'd3.
REQ-021 One sub-module, rr_pick3: combinational round-robin picker taking req[2:0] and rr_ptr and returning a valid flag plus a 2-bit index; all other logic stays flat.

Verification
REQ-022 Single requester: req = 3'b001 held with addr 9'h005, we 4'hF, din 32'hDEADBEEF; expected response:
- gnt = 001 one cycle after req;
- bram_en = 1, bram_addr = 5, bram_din = DEADBEEF;
- a rel pulse gives gnt = 0 next cycle.
REQ-023 Contention: req = 3'b111 held and each owner releases after 2 cycles; grant order must be 0, 1, 2, 0, with exactly one TURNAROUND cycle between grants.
REQ-024 Illegal release: owner 1 holds the grant while rel = 3'b101 pulses; gnt stays 010 and the bram_* outputs are unchanged.
REQ-025 Reset mid-burst: owner 2 granted with bram_we = 4'b0011, then rst asserted; next cycle gnt = 0, bram_en = 0, owner = 3, and the first grant after reset goes to requester 0 when all three request.
REQ-026 With BRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, requester 0 holds req with no rel; expected response:
- timeout pulses once, 16 cycles after gnt rose;
- gnt clears;
- the pending requester 1 is granted 2 cycles later.
